// File: rtl/reg_file_pkg.sv
// Shared widths, reset value and types for the 2-read/1-write register file.
// Bypass behaviour is selected by the REG_FILE_BYPASS_EN macro in reg_file_read_port.
package reg_file_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_data_t RESET_VAL = {DATA_W{1'b1}};
    localparam reg_data_t REG_ZERO  = '0;

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: zero-check on entry 0, optional write bypass, output data flop.
// Macro REG_FILE_BYPASS_EN: defined = write-first bypass, undefined = read-first (old value).
module reg_file_read_port #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic              bypass_hit;
    logic [DATA_W-1:0] lookup;

`ifdef REG_FILE_BYPASS_EN
    assign bypass_hit = wr_en && (wr_addr == rd_addr);
`else
    // Read-first build: the write strobe and address do not affect the read path.
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr};
    assign bypass_hit    = 1'b0;
`endif

    // Entry 0 wins over the bypass so a write aimed at 0 never leaks through.
    always_comb begin
        lookup = mem[rd_addr];
        if (rd_addr == '0) begin
            lookup = '0;
        end else if (bypass_hit) begin
            lookup = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_req) begin
            rd_data <= lookup;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write flop-based register file with registered reads and entry 0 hardwired to zero.
// Same-address write/read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_2r1w #(
    parameter int                         DATA_W    = reg_file_pkg::DATA_W,
    parameter int                         ADDR_W    = reg_file_pkg::ADDR_W,
    parameter logic [DATA_W-1:0]          RESET_VAL = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    import reg_file_pkg::*;

    localparam int NUM_ENTRIES = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NUM_ENTRIES];

    // Entry 0 is loaded with zero on reset and never written, so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem[i] <= (i == 0) ? '0 : RESET_VAL;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Handshake: rd_req is sampled on every posedge with no backpressure; rd_valid is
    // exactly that sample delayed one cycle, and rd_data_a/b hold when rd_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
        end
    end

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .clk     (clk),
        .reset   (reset),
        .rd_req  (rd_req),
        .rd_addr (rd_addr_a),
        .mem     (mem),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_a)
    );

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .clk     (clk),
        .reset   (reset),
        .rd_req  (rd_req),
        .rd_addr (rd_addr_b),
        .mem     (mem),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_b)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios plus randomized traffic
// against an array-based model of the register file contents.
module tb_reg_file_2r1w;

    import reg_file_pkg::*;

    localparam int DW = DATA_W;
    localparam int AW = ADDR_W;
    localparam int NE = 2 ** ADDR_W;
    localparam int W  = 1 + 2 * DW;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;

    always #5 clk = ~clk;

    reg_file_2r1w dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_valid  (rd_valid),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    // ---------------- reference model / scoreboard ----------------
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] model_mem [NE];
    logic [DW-1:0] hold_a;
    logic [DW-1:0] hold_b;
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  e;

    function automatic logic [DW-1:0] model_lookup(input logic [AW-1:0] addr, input logic wen,
                                                   input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
        if (addr == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (wen && waddr == addr) return wdata;
`endif
        return model_mem[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) model_mem[i] = (i == 0) ? '0 : RESET_VAL;
        hold_a = '0;
        hold_b = '0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of stimulus; outputs are observed 1 time unit after the edge.
    task automatic drive(input logic wen, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                         input logic req, input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        wr_en = wen; wr_addr = waddr; wr_data = wdata;
        rd_req = req; rd_addr_a = a; rd_addr_b = b;
        ea = model_lookup(a, wen, waddr, wdata);
        eb = model_lookup(b, wen, waddr, wdata);
        @(posedge clk);
        #1;
        if (wen && waddr != 0) model_mem[waddr] = wdata;
        if (req) begin
            hold_a = ea;
            hold_b = eb;
        end
        exp_q.push_back({req, hold_a, hold_b});
        wr_en = 1'b0;
        rd_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rd_valid, rd_data_a, rd_data_b} !== {1'b0, {DW{1'b0}}, {DW{1'b0}}}) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b a=%h b=%h expected valid=0 a=0 b=0", rd_valid, rd_data_a, rd_data_b);
        end
        reset = 1'b0;
        model_reset();
        drive(1'b0, 3'd0, '0, 1'b1, 3'd3, 3'd7);
        checks++;
        if ({rd_valid, rd_data_a, rd_data_b} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL reset_values: got valid=%b a=%h b=%h expected valid=1 a=ffffffff b=ffffffff", rd_valid, rd_data_a, rd_data_b);
        end
        exp_q.delete();
    endtask

    task automatic test_write_read();
        drive(1'b1, 3'd5, 32'h1234_5678, 1'b0, 3'd0, 3'd0);
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_no_valid: got valid=%b expected 0", rd_valid);
        end
        drive(1'b0, 3'd0, '0, 1'b1, 3'd5, 3'd0);
        checks++;
        if ({rd_valid, rd_data_a, rd_data_b} !== {1'b1, 32'h1234_5678, 32'h0}) begin
            failures++;
            $display("FAIL write_read: got valid=%b a=%h b=%h expected valid=1 a=12345678 b=0", rd_valid, rd_data_a, rd_data_b);
        end
        exp_q.delete();
    endtask

    task automatic test_write_zero();
        drive(1'b1, 3'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 3'd0);
        drive(1'b0, 3'd0, '0, 1'b1, 3'd0, 3'd0);
        checks++;
        if ({rd_valid, rd_data_a} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL write_zero: got valid=%b a=%h expected valid=1 a=0", rd_valid, rd_data_a);
        end
        drive(1'b1, 3'd0, 32'hDEAD_BEEF, 1'b1, 3'd0, 3'd0);
        checks++;
        if ({rd_data_a, rd_data_b} !== {32'h0, 32'h0}) begin
            failures++;
            $display("FAIL write_zero_same_cycle: got a=%h b=%h expected a=0 b=0", rd_data_a, rd_data_b);
        end
        exp_q.delete();
    endtask

    task automatic test_hazard();
        logic [DW-1:0] exp_a;
`ifdef REG_FILE_BYPASS_EN
        exp_a = 32'h5555_FFFF;
`else
        exp_a = 32'hAAAA_0000;
`endif
        drive(1'b1, 3'd2, 32'hAAAA_0000, 1'b0, 3'd0, 3'd0);
        drive(1'b1, 3'd2, 32'h5555_FFFF, 1'b1, 3'd2, 3'd2);
        checks++;
        if (rd_data_a !== exp_a) begin
            failures++;
            $display("FAIL hazard_same_edge: got a=%h expected %h", rd_data_a, exp_a);
        end
        checks++;
        if (rd_data_b !== exp_a) begin
            failures++;
            $display("FAIL hazard_port_b_same_addr: got b=%h expected %h", rd_data_b, exp_a);
        end
        drive(1'b0, 3'd0, '0, 1'b1, 3'd2, 3'd0);
        checks++;
        if ({rd_valid, rd_data_a} !== {1'b1, 32'h5555_FFFF}) begin
            failures++;
            $display("FAIL hazard_next_read: got valid=%b a=%h expected valid=1 a=5555ffff", rd_valid, rd_data_a);
        end
        exp_q.delete();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] v;
        for (int k = 1; k <= 4; k++) drive(1'b1, AW'(k), 32'h1000_0001 * k, 1'b0, 3'd0, 3'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 3'd0, '0, 1'b1, AW'(k), AW'(5 - k));
            v = 32'h1000_0001 * k;
            checks++;
            if ({rd_valid, rd_data_a, rd_data_b} !== {1'b1, v, 32'h1000_0001 * (5 - k)}) begin
                failures++;
                $display("FAIL streaming_%0d: got valid=%b a=%h b=%h expected valid=1 a=%h b=%h",
                         k, rd_valid, rd_data_a, rd_data_b, v, 32'h1000_0001 * (5 - k));
            end
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 3'd4, 32'hCAFE_0000, 1'b0, 3'd1, 3'd2);
            checks++;
            if ({rd_valid, rd_data_a, rd_data_b} !== {1'b0, 32'h4000_0004, 32'h1000_0001}) begin
                failures++;
                $display("FAIL streaming_idle_hold_%0d: got valid=%b a=%h b=%h expected valid=0 a=40000004 b=10000001",
                         k, rd_valid, rd_data_a, rd_data_b);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 3'd6, 32'h0BAD_F00D, 1'b1, 3'd6, 3'd1);
        rd_req = 1'b1; rd_addr_a = 3'd6; rd_addr_b = 3'd6;
        reset = 1'b1;
        #1;
        checks++;
        if ({rd_valid, rd_data_a, rd_data_b} !== {1'b0, {DW{1'b0}}, {DW{1'b0}}}) begin
            failures++;
            $display("FAIL async_reset_immediate: got valid=%b a=%h b=%h expected valid=0 a=0 b=0", rd_valid, rd_data_a, rd_data_b);
        end
        #2;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < NE; k += 2) begin
            drive(1'b0, 3'd0, '0, 1'b1, AW'(k), AW'(k + 1));
            checks++;
            if ({rd_valid, rd_data_a, rd_data_b} !== {1'b1, (k == 0) ? {DW{1'b0}} : RESET_VAL, RESET_VAL}) begin
                failures++;
                $display("FAIL async_reset_contents_%0d: got valid=%b a=%h b=%h expected reset values", k, rd_valid, rd_data_a, rd_data_b);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, NE - 1)), DW'($urandom),
                  1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, NE - 1)), AW'($urandom_range(0, NE - 1)));
            e = exp_q.pop_front();
            checks++;
            if ({rd_valid, rd_data_a, rd_data_b} !== e) begin
                failures++;
                $display("FAIL random_%0d: got valid=%b a=%h b=%h expected valid=%b a=%h b=%h",
                         n, rd_valid, rd_data_a, rd_data_b, e[W-1], e[2*DW-1:DW], e[DW-1:0]);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_write_zero();
        test_hazard();
        test_streaming();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
